line_sum_generator: RTL and testbench

Producer side of the line-sum interface: consumes a raster pixel stream plus per-template reference pixels and emits, once per image line, the three line sums consumed by the line-sum accumulator stage (ΣI², ΣI and ΣT·I per template). It sits between the pixel/template fetch logic and the line-sum accumulators. It adds a valid/ready handshake and line/frame bookkeeping, so the accumulators receive exactly one update per completed line.

---
 rtl/line_sum_generator_pkg.sv | 23 ++
 rtl/line_sum_generator_pixel_mac_lane.sv | 31 +++
 rtl/line_sum_generator.sv | 115 +++++++++++
 tb/tb_line_sum_generator.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_sum_generator_pkg.sv
// Shared widths, types and output FSM encoding for the line-sum producer.
package line_sum_generator_pkg;

   localparam int DEF_PIXEL_SIZE    = 8;
   localparam int DEF_LINE_SIZE     = 64;
   localparam int DEF_NUM_OF_LINES  = 64;
   localparam int DEF_NUM_TEMPLATES = 4;

   function automatic int ls_width(input int line_size, input int pixel_size);
      return $clog2(line_size) + 2 * pixel_size;
   endfunction

   localparam int LS_W = ls_width(DEF_LINE_SIZE, DEF_PIXEL_SIZE);

   typedef logic [LS_W-1:0]           line_sum_t;
   typedef logic [DEF_PIXEL_SIZE-1:0] pixel_t;

   typedef enum logic [0:0] {
      EMPTY   = 1'b0,
      PENDING = 1'b1
   } out_state_e;

endpackage

// File: rtl/line_sum_generator_pixel_mac_lane.sv
// One unsigned multiply-accumulate lane; o_sum_next includes the current beat
// so the owner can capture a finished line on its last beat.
module pixel_mac_lane
   import line_sum_generator_pkg::*;
#(
   parameter int IN_W  = DEF_PIXEL_SIZE,
   parameter int ACC_W = LS_W
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_en,
   input  logic             i_clr,
   input  logic [IN_W-1:0]  i_a,
   input  logic [IN_W-1:0]  i_b,
   output logic [ACC_W-1:0] o_sum_next
);

   logic [2*IN_W-1:0] w_prod;
   logic [ACC_W-1:0]  r_acc;

   assign w_prod     = {{IN_W{1'b0}}, i_a} * {{IN_W{1'b0}}, i_b};
   assign o_sum_next = r_acc + ACC_W'(w_prod);

   always_ff @(posedge i_clk) begin
      if (i_reset)
         r_acc <= '0;
      else if (i_en)
         r_acc <= i_clr ? '0 : o_sum_next;
   end

endmodule

// File: rtl/line_sum_generator.sv
// Per-line producer of sum(I^2), sum(I), sum(T_k*I); result registered one cycle after
// the last beat; only a line's last beat stalls, and only while the previous result is unread.
module line_sum_generator
   import line_sum_generator_pkg::*;
#(
   parameter int PIXEL_SIZE    = DEF_PIXEL_SIZE,
   parameter int LINE_SIZE     = DEF_LINE_SIZE,
   parameter int NUM_OF_LINES  = DEF_NUM_OF_LINES,
   parameter int NUM_TEMPLATES = DEF_NUM_TEMPLATES,
   localparam int SUM_W = ls_width(LINE_SIZE, PIXEL_SIZE),
   localparam int CNT_W = $clog2(LINE_SIZE),
   localparam int LN_W  = $clog2(NUM_OF_LINES)
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_pix_valid,
   output logic                  o_pix_ready,
   input  logic [PIXEL_SIZE-1:0] i_pix_I,
   input  logic [PIXEL_SIZE-1:0] i_pix_T [NUM_TEMPLATES],
   output logic                  o_out_valid,
   input  logic                  i_out_ready,
   output logic [SUM_W-1:0]      o_I_square_out_line_sum,
   output logic [SUM_W-1:0]      o_I_out_line_sum,
   output logic [SUM_W-1:0]      o_T_x_I_out_lines_sum [NUM_TEMPLATES],
   output logic [LN_W-1:0]       o_line_idx,
   output logic                  o_out_last_line
);

   localparam int NUM_LANES = NUM_TEMPLATES + 2;
   localparam logic [PIXEL_SIZE-1:0] ONE = PIXEL_SIZE'(1);

   logic [CNT_W-1:0]      r_pix_cnt;
   logic [LN_W-1:0]       r_frame_line;
   out_state_e            r_state;
   logic [SUM_W-1:0]      r_sq_sum;
   logic [SUM_W-1:0]      r_i_sum;
   logic [SUM_W-1:0]      r_txi_sum [NUM_TEMPLATES];
   logic [LN_W-1:0]       r_line_idx;
   logic                  r_last_line;

   logic                  w_last_beat;
   logic                  w_accept;
   logic                  w_load;
   logic [PIXEL_SIZE-1:0] w_a [NUM_LANES];
   logic [PIXEL_SIZE-1:0] w_b [NUM_LANES];
   logic [SUM_W-1:0]      w_next [NUM_LANES];

   assign w_last_beat = (r_pix_cnt == CNT_W'(LINE_SIZE - 1));
   assign o_pix_ready = !(w_last_beat && (r_state == PENDING) && !i_out_ready);
   assign w_accept    = i_pix_valid && o_pix_ready;
   assign w_load      = w_accept && w_last_beat;

   // Lane 0 is I*I, lane 1 is I*1, lanes 2.. are T_k*I.
   always_comb begin
      w_a[0] = i_pix_I;
      w_b[0] = i_pix_I;
      w_a[1] = i_pix_I;
      w_b[1] = ONE;
      for (int k = 0; k < NUM_TEMPLATES; k++) begin
         w_a[k+2] = i_pix_T[k];
         w_b[k+2] = i_pix_I;
      end
   end

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      pixel_mac_lane #(
         .IN_W  (PIXEL_SIZE),
         .ACC_W (SUM_W)
      ) u_lane (
         .i_clk      (i_clk),
         .i_reset    (i_reset),
         .i_en       (w_accept),
         .i_clr      (w_last_beat),
         .i_a        (w_a[g]),
         .i_b        (w_b[g]),
         .o_sum_next (w_next[g])
      );
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_pix_cnt    <= '0;
         r_frame_line <= '0;
         r_state      <= EMPTY;
         r_sq_sum     <= '0;
         r_i_sum      <= '0;
         for (int k = 0; k < NUM_TEMPLATES; k++) r_txi_sum[k] <= '0;
         r_line_idx   <= '0;
         r_last_line  <= 1'b0;
      end else begin
         if (w_accept)
            r_pix_cnt <= w_last_beat ? '0 : r_pix_cnt + 1'b1;
         // A completing line overwrites the register in the same cycle the old result drains.
         if (w_load) begin
            r_state     <= PENDING;
            r_sq_sum    <= w_next[0];
            r_i_sum     <= w_next[1];
            for (int k = 0; k < NUM_TEMPLATES; k++) r_txi_sum[k] <= w_next[k+2];
            r_line_idx  <= r_frame_line;
            r_last_line <= (r_frame_line == LN_W'(NUM_OF_LINES - 1));
            r_frame_line <= (r_frame_line == LN_W'(NUM_OF_LINES - 1)) ? '0 : r_frame_line + 1'b1;
         end else if (i_out_ready) begin
            r_state <= EMPTY;
         end
      end
   end

   assign o_out_valid             = (r_state == PENDING);
   assign o_I_square_out_line_sum = r_sq_sum;
   assign o_I_out_line_sum        = r_i_sum;
   assign o_T_x_I_out_lines_sum   = r_txi_sum;
   assign o_line_idx              = r_line_idx;
   assign o_out_last_line         = r_last_line;

endmodule

// File: tb/tb_line_sum_generator.sv
// Bench for line_sum_generator: scoreboard of expected line sums plus per-scenario checks.
module tb_line_sum_generator;

   localparam int PW = 8;
   localparam int LS = 4;
   localparam int NT = 2;
   localparam int NL = 3;
   localparam int SW = 18;

   typedef struct {
      logic [SW-1:0] sq;
      logic [SW-1:0] s;
      logic [SW-1:0] t0;
      logic [SW-1:0] t1;
      logic [1:0]    idx;
      logic          last;
   } exp_t;

   logic          clk = 1'b0;
   logic          i_reset;
   logic          i_pix_valid;
   logic          o_pix_ready;
   logic [PW-1:0] i_pix_I;
   logic [PW-1:0] i_pix_T [NT];
   logic          o_out_valid;
   logic          i_out_ready;
   logic [SW-1:0] o_sq;
   logic [SW-1:0] o_s;
   logic [SW-1:0] o_t [NT];
   logic [1:0]    o_line_idx;
   logic          o_last;

   int   total = 0;
   int   bad   = 0;
   int   n_hs  = 0;
   bit   rnd   = 1'b0;
   exp_t sb[$];
   exp_t mon_e;

   int     m_cnt, m_line;
   longint m_sq, m_s, m_t0, m_t1;

   line_sum_generator #(
      .PIXEL_SIZE    (PW),
      .LINE_SIZE     (LS),
      .NUM_OF_LINES  (NL),
      .NUM_TEMPLATES (NT)
   ) dut (
      .i_clk                   (clk),
      .i_reset                 (i_reset),
      .i_pix_valid             (i_pix_valid),
      .o_pix_ready             (o_pix_ready),
      .i_pix_I                 (i_pix_I),
      .i_pix_T                 (i_pix_T),
      .o_out_valid             (o_out_valid),
      .i_out_ready             (i_out_ready),
      .o_I_square_out_line_sum (o_sq),
      .o_I_out_line_sum        (o_s),
      .o_T_x_I_out_lines_sum   (o_t),
      .o_line_idx              (o_line_idx),
      .o_out_last_line         (o_last)
   );

   always #5 clk = ~clk;

   // Every output handshake is matched against the oldest expected line.
   always @(negedge clk) begin
      if (!i_reset && o_out_valid && i_out_ready) begin
         n_hs++;
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected: got line_idx=%0d s=%0d, want no output", o_line_idx, o_s);
         end else begin
            mon_e = sb.pop_front();
            if (o_sq !== mon_e.sq || o_s !== mon_e.s || o_t[0] !== mon_e.t0 || o_t[1] !== mon_e.t1 ||
                o_line_idx !== mon_e.idx || o_last !== mon_e.last) begin
               bad++;
               $display("FAIL sb_line: got sq=%0d s=%0d t0=%0d t1=%0d idx=%0d last=%0d, want sq=%0d s=%0d t0=%0d t1=%0d idx=%0d last=%0d",
                        o_sq, o_s, o_t[0], o_t[1], o_line_idx, o_last,
                        mon_e.sq, mon_e.s, mon_e.t0, mon_e.t1, mon_e.idx, mon_e.last);
            end
         end
      end
   end

   task automatic model_reset();
      m_cnt = 0; m_line = 0;
      m_sq = 0; m_s = 0; m_t0 = 0; m_t1 = 0;
      sb.delete();
   endtask

   task automatic model_beat(input int pi, input int p0, input int p1);
      exp_t e;
      m_sq += pi * pi;
      m_s  += pi;
      m_t0 += p0 * pi;
      m_t1 += p1 * pi;
      if (m_cnt == LS - 1) begin
         e.sq = SW'(m_sq); e.s = SW'(m_s); e.t0 = SW'(m_t0); e.t1 = SW'(m_t1);
         e.idx = 2'(m_line); e.last = (m_line == NL - 1);
         sb.push_back(e);
         m_line = (m_line + 1) % NL;
         m_cnt = 0; m_sq = 0; m_s = 0; m_t0 = 0; m_t1 = 0;
      end else begin
         m_cnt++;
      end
   endtask

   // Called and returns at posedge+1; presents one beat until it is accepted.
   task automatic send_beat(input int pi, input int p0, input int p1, output int waits);
      bit ok = 1'b0;
      waits = 0;
      i_pix_valid = 1'b1;
      i_pix_I = PW'(pi); i_pix_T[0] = PW'(p0); i_pix_T[1] = PW'(p1);
      for (int w = 0; w < 50 && !ok; w++) begin
         if (rnd) i_out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (o_pix_ready) ok = 1'b1;
         else waits++;
         @(posedge clk); #1;
      end
      i_pix_valid = 1'b0;
      if (!ok) begin
         total++; bad++;
         $display("FAIL beat_timeout: got pix_ready=0 for 50 cycles, want 1");
      end else begin
         model_beat(pi, p0, p1);
      end
   endtask

   task automatic send_line(input int pi[4], input int p0, input int p1);
      int w;
      for (int b = 0; b < LS; b++) send_beat(pi[b], p0, p1, w);
   endtask

   task automatic test_reset();
      i_reset = 1'b1; i_pix_valid = 1'b0; i_out_ready = 1'b1;
      i_pix_I = '0; i_pix_T[0] = '0; i_pix_T[1] = '0;
      repeat (3) @(posedge clk);
      #1 i_reset = 1'b0;
      model_reset();
      @(negedge clk);
      total++; if (o_out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", o_out_valid); end
      total++; if (o_pix_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", o_pix_ready); end
      total++; if (o_sq !== '0 || o_s !== '0 || o_t[0] !== '0 || o_t[1] !== '0) begin
         bad++; $display("FAIL reset_sums: got %0d %0d %0d %0d want 0", o_sq, o_s, o_t[0], o_t[1]);
      end
      total++; if (o_line_idx !== 2'd0 || o_last !== 1'b0) begin
         bad++; $display("FAIL reset_idx: got idx=%0d last=%b want 0/0", o_line_idx, o_last);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      send_line('{1, 2, 3, 4}, 2, 255);
      @(negedge clk);
      total++; if (o_out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b want 1", o_out_valid); end
      total++; if (o_s !== 18'd10 || o_sq !== 18'd30) begin bad++; $display("FAIL basic_i: got s=%0d sq=%0d want 10/30", o_s, o_sq); end
      total++; if (o_t[0] !== 18'd20 || o_t[1] !== 18'd2550) begin bad++; $display("FAIL basic_txi: got %0d %0d want 20/2550", o_t[0], o_t[1]); end
      total++; if (o_line_idx !== 2'd0) begin bad++; $display("FAIL basic_idx: got %0d want 0", o_line_idx); end
      @(posedge clk); #1;
   endtask

   task automatic test_max();
      send_line('{255, 255, 255, 255}, 255, 255);
      @(negedge clk);
      total++; if (o_sq !== 18'd260100 || o_s !== 18'd1020) begin bad++; $display("FAIL max_i: got sq=%0d s=%0d want 260100/1020", o_sq, o_s); end
      total++; if (o_t[0] !== 18'd260100 || o_t[1] !== 18'd260100) begin bad++; $display("FAIL max_txi: got %0d %0d want 260100", o_t[0], o_t[1]); end
      @(posedge clk); #1;
   endtask

   task automatic test_wrap();
      send_line('{7, 0, 9, 1}, 3, 4);
      @(negedge clk);
      total++; if (o_line_idx !== 2'd2 || o_last !== 1'b1) begin bad++; $display("FAIL wrap_last: got idx=%0d last=%b want 2/1", o_line_idx, o_last); end
      @(posedge clk); #1;
      send_line('{8, 8, 0, 2}, 1, 0);
      @(negedge clk);
      total++; if (o_line_idx !== 2'd0 || o_last !== 1'b0) begin bad++; $display("FAIL wrap_first: got idx=%0d last=%b want 0/0", o_line_idx, o_last); end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      int w;
      i_out_ready = 1'b0;
      send_line('{3, 3, 3, 3}, 1, 2);
      for (int b = 0; b < LS - 1; b++) begin
         send_beat(b + 1, 5, 6, w);
         total++; if (w !== 0) begin bad++; $display("FAIL bp_early_beat%0d: got %0d stall cycles want 0", b, w); end
      end
      i_pix_valid = 1'b1; i_pix_I = 8'd4; i_pix_T[0] = 8'd5; i_pix_T[1] = 8'd6;
      repeat (2) begin
         @(negedge clk);
         total++; if (o_pix_ready !== 1'b0) begin bad++; $display("FAIL bp_stall: got pix_ready=%b want 0", o_pix_ready); end
         total++; if (o_out_valid !== 1'b1 || o_s !== 18'd12) begin bad++; $display("FAIL bp_hold: got valid=%b s=%0d want 1/12", o_out_valid, o_s); end
         @(posedge clk); #1;
      end
      i_out_ready = 1'b1;
      @(negedge clk);
      total++; if (o_pix_ready !== 1'b1) begin bad++; $display("FAIL bp_release: got pix_ready=%b want 1", o_pix_ready); end
      model_beat(4, 5, 6);
      @(posedge clk); #1;
      i_pix_valid = 1'b0;
      @(negedge clk);
      total++; if (o_out_valid !== 1'b1 || o_s !== 18'd10 || o_t[1] !== 18'd60) begin
         bad++; $display("FAIL bp_next: got valid=%b s=%0d t1=%0d want 1/10/60", o_out_valid, o_s, o_t[1]);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_midline();
      int w;
      send_beat(9, 9, 9, w);
      send_beat(9, 9, 9, w);
      i_reset = 1'b1;
      @(posedge clk); #1;
      i_reset = 1'b0;
      model_reset();
      @(negedge clk);
      total++; if (o_out_valid !== 1'b0 || o_pix_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_hs: got valid=%b ready=%b want 0/1", o_out_valid, o_pix_ready); end
      total++; if (o_sq !== '0 || o_s !== '0 || o_t[0] !== '0 || o_t[1] !== '0 || o_line_idx !== 2'd0) begin
         bad++; $display("FAIL rst_mid_out: got sq=%0d s=%0d t0=%0d t1=%0d idx=%0d want 0", o_sq, o_s, o_t[0], o_t[1], o_line_idx);
      end
      @(posedge clk); #1;
      send_line('{5, 5, 5, 5}, 1, 1);
      @(negedge clk);
      total++; if (o_s !== 18'd20 || o_line_idx !== 2'd0) begin bad++; $display("FAIL rst_mid_line: got s=%0d idx=%0d want 20/0", o_s, o_line_idx); end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      int w;
      int hs0;
      hs0 = n_hs;
      rnd = 1'b1;
      for (int l = 0; l < 3; l++) begin
         for (int b = 0; b < LS; b++) begin
            repeat ($urandom_range(0, 2)) begin
               i_out_ready = 1'($urandom_range(0, 1));
               @(posedge clk); #1;
            end
            send_beat($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), w);
         end
      end
      rnd = 1'b0;
      i_out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      total++; if (n_hs - hs0 !== 3) begin bad++; $display("FAIL rand_handshakes: got %0d want 3", n_hs - hs0); end
      total++; if (sb.size() !== 0) begin bad++; $display("FAIL rand_drain: got %0d queued want 0", sb.size()); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_max();
      test_wrap();
      test_backpressure();
      test_reset_midline();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
